branch_resolve_unit: RTL and testbench

Consumer and write-side partner of the branch history table. It queues every prediction issued at fetch and retires them in order when execute resolves each branch. For each retired branch it drives a registered update to the BHT write port (write_addr, was_taken). On a misprediction it raises a one-cycle flush with the redirect PC, and it keeps branch and mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 167 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// Keeps every branch prediction issued at fetch in a small in-order queue and
// retires the oldest one when execute resolves it. Each retirement drives a
// registered write to the branch history table (upd_*). A retirement whose
// prediction disagrees with the real outcome raises a one-cycle flush with
// the redirect PC and discards everything still in flight. Retired and
// mispredicted branches are counted with saturating 16-bit counters.
//
// Ports
//   clk, arst_n        clock (rising edge), asynchronous active-low reset
//   en                 global enable; 0 freezes all state, pulses read 0
//   pred_valid/idx/taken, pred_ready
//                      fetch-side push of {BHT index, predicted direction}
//   res_valid/taken/next_pc
//                      execute-side resolve of the oldest in-flight branch
//   upd_valid/addr/taken
//                      registered BHT write port, one cycle after a retire
//   flush, redirect_pc one-cycle flush pulse and the fetch redirect target
//   empty              nothing in flight
//   res_err            sticky: a resolve arrived with nothing in flight
//   branch_cnt, mispred_cnt
//                      saturating retire / misprediction counters
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             pred_valid,
    input  logic [LOWER-1:0] pred_idx,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_next_pc,
    output logic             upd_valid,
    output logic [LOWER-1:0] upd_addr,
    output logic             upd_taken,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             empty,
    output logic             res_err,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    // One extra bit so that "full" (count == DEPTH) and "empty" differ.
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr_inc;
    logic [CNT_W-1:0] count;
    logic [LOWER-1:0] idx_mem   [DEPTH];
    logic             taken_mem [DEPTH];

    logic full, push, pop, mispred, err_hit;

    // Occupancy is taken at the start of the cycle: a full queue refuses a
    // push even if a pop happens in the same cycle.
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign pred_ready = (state == RUN) && !full;

    assign push    = en && pred_valid && pred_ready;
    // While flushing the queue is always empty and res_valid is ignored, so
    // the RUN qualifier matters only for the error flag.
    assign pop     = en && res_valid && (state == RUN) && !empty;
    assign err_hit = en && res_valid && (state == RUN) && empty;
    assign mispred = pop && (taken_mem[rd_ptr] != res_taken);

    assign wr_ptr_inc = push ? wr_ptr + PTR_W'(1) : wr_ptr;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispred) state_nxt = FLUSH;
            FLUSH:   if (en)      state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the record array has no reset; the pointers and occupancy alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr]   <= pred_idx;
            taken_mem[wr_ptr] <= pred_taken;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, outputs and statistics
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            upd_valid   <= 1'b0;
            upd_addr    <= '0;
            upd_taken   <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            res_err     <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            // Pulses are single-cycle and drop whenever en is low.
            upd_valid <= pop;
            flush     <= mispred;

            if (mispred) begin
                // Discard all in-flight records, including a push taken in
                // this very cycle, by equalising the pointers.
                wr_ptr <= wr_ptr_inc;
                rd_ptr <= wr_ptr_inc;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr_inc;
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end

            if (pop) begin
                upd_addr  <= idx_mem[rd_ptr];
                upd_taken <= res_taken;
                if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
            end

            if (mispred) begin
                redirect_pc <= res_next_pc;
                if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
            end

            if (err_hit) res_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// Bench for branch_resolve_unit (LOWER=5, DEPTH=4, PC_W=32). The reference
// model is a queue of {idx, taken} records plus a few flags; each cycle it
// retires the front record and applies the flush / error / counter rules.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int LOWER = 5;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             en;
    logic             pred_valid;
    logic [LOWER-1:0] pred_idx;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic [PC_W-1:0]  res_next_pc;
    logic             upd_valid;
    logic [LOWER-1:0] upd_addr;
    logic             upd_taken;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             empty;
    logic             res_err;
    logic [15:0]      branch_cnt;
    logic [15:0]      mispred_cnt;

    branch_resolve_unit #(.LOWER(LOWER), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .en          (en),
        .pred_valid  (pred_valid),
        .pred_idx    (pred_idx),
        .pred_taken  (pred_taken),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_next_pc (res_next_pc),
        .upd_valid   (upd_valid),
        .upd_addr    (upd_addr),
        .upd_taken   (upd_taken),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .empty       (empty),
        .res_err     (res_err),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [LOWER-1:0] idx;
        logic             taken;
    } rec_t;

    rec_t             q[$];
    bit               m_in_flush;
    bit               m_err;
    int               m_bcnt, m_mcnt;
    logic             m_upd_valid, m_upd_taken, m_flush;
    logic [LOWER-1:0] m_upd_addr;
    logic [PC_W-1:0]  m_redirect;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_in_flush  = 0;
        m_err       = 0;
        m_bcnt      = 0;
        m_mcnt      = 0;
        m_upd_valid = 0;
        m_upd_taken = 0;
        m_upd_addr  = '0;
        m_flush     = 0;
        m_redirect  = '0;
    endtask

    task automatic model_step(input bit e, input bit pv, input logic [LOWER-1:0] pi,
                              input bit pt, input bit rv, input bit rt,
                              input logic [PC_W-1:0] pc);
        bit   can_push;
        rec_t r;
        m_upd_valid = 0;
        m_flush     = 0;
        if (!e) return;
        if (m_in_flush) begin
            m_in_flush = 0;
            return;
        end
        can_push = pv && (q.size() < DEPTH);
        if (rv) begin
            if (q.size() == 0) begin
                m_err = 1;
            end else begin
                r = q.pop_front();
                m_upd_valid = 1;
                m_upd_addr  = r.idx;
                m_upd_taken = rt;
                if (m_bcnt < 65535) m_bcnt++;
                if (r.taken != rt) begin
                    if (m_mcnt < 65535) m_mcnt++;
                    m_flush    = 1;
                    m_redirect = pc;
                    q.delete();
                    m_in_flush = 1;
                    can_push   = 0;
                end
            end
        end
        if (can_push) q.push_back('{idx: pi, taken: pt});
    endtask

    task automatic check_regs();
        check("upd_valid",   upd_valid,   m_upd_valid);
        check("upd_addr",    upd_addr,    m_upd_addr);
        check("upd_taken",   upd_taken,   m_upd_taken);
        check("flush",       flush,       m_flush);
        check("redirect_pc", redirect_pc, m_redirect);
        check("res_err",     res_err,     m_err);
        check("branch_cnt",  branch_cnt,  m_bcnt[15:0]);
        check("mispred_cnt", mispred_cnt, m_mcnt[15:0]);
        check("empty",       empty,       q.size() == 0);
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cyc(input bit e, input bit pv, input logic [LOWER-1:0] pi, input bit pt,
                       input bit rv, input bit rt, input logic [PC_W-1:0] pc);
        en = e; pred_valid = pv; pred_idx = pi; pred_taken = pt;
        res_valid = rv; res_taken = rt; res_next_pc = pc;
        #1;
        check("pred_ready", pred_ready, !m_in_flush && (q.size() < DEPTH));
        check("empty_pre",  empty,      q.size() == 0);
        model_step(e, pv, pi, pt, rv, rt, pc);
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        cyc(1, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic push(input logic [LOWER-1:0] pi, input bit pt);
        cyc(1, 1, pi, pt, 0, 0, '0);
    endtask

    task automatic resolve(input bit rt, input logic [PC_W-1:0] pc);
        cyc(1, 0, '0, 0, 1, rt, pc);
    endtask

    initial begin
        bit               r_en, r_pv, r_pt, r_rv, r_rt, guess;
        logic [LOWER-1:0] r_idx;
        logic [PC_W-1:0]  r_pc;

        // ---------------- reset ----------------
        arst_n = 1'b0;
        en = 0; pred_valid = 0; pred_idx = '0; pred_taken = 0;
        res_valid = 0; res_taken = 0; res_next_pc = '0;
        model_reset();
        @(negedge clk);
        check_regs();
        arst_n = 1'b1;
        #1;
        check("rst_pred_ready", pred_ready, 1'b1);
        check("rst_empty",      empty,      1'b1);
        @(negedge clk);

        // ---------------- single correct retire ----------------
        push(5'd3, 1);
        resolve(1, 32'h100);
        check("t1_upd_valid", upd_valid,   1'b1);
        check("t1_upd_addr",  upd_addr,    5'd3);
        check("t1_upd_taken", upd_taken,   1'b1);
        check("t1_flush",     flush,       1'b0);
        check("t1_bcnt",      branch_cnt,  16'd1);
        check("t1_mcnt",      mispred_cnt, 16'd0);
        idle();
        check("t1_upd_drop",  upd_valid,   1'b0);

        // ---------------- fill, refuse, in-order drain, wrap ----------------
        for (int i = 1; i <= 4; i++) push(LOWER'(i), 1);
        check("t2_full_ready", pred_ready, 1'b0);
        push(5'd5, 1);                         // refused
        for (int i = 1; i <= 4; i++) begin
            resolve(1, '0);
            check("t2_order", upd_addr, LOWER'(i));
        end
        check("t2_drained", empty, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push(LOWER'(8 + i), i[0]);
            resolve(i[0], '0);
            check("t2_wrap", upd_addr, LOWER'(8 + i));
        end

        // ---------------- misprediction ----------------
        push(5'd7, 0);
        resolve(1, 32'h0000_0040);
        check("t3_flush",    flush,       1'b1);
        check("t3_redirect", redirect_pc, 32'h0000_0040);
        check("t3_addr",     upd_addr,    5'd7);
        check("t3_taken",    upd_taken,   1'b1);
        check("t3_mcnt",     mispred_cnt, 16'd1);
        check("t3_empty",    empty,       1'b1);
        check("t3_ready",    pred_ready,  1'b0);
        idle();
        check("t3_ready_back", pred_ready, 1'b1);
        check("t3_flush_drop", flush,      1'b0);

        // ---------------- mispredict discards queue and same-cycle push ----------------
        push(5'd10, 1);
        push(5'd11, 1);
        cyc(1, 1, 5'd12, 1, 1, 0, 32'h0000_0800);
        check("t4_flush", flush, 1'b1);
        check("t4_empty", empty, 1'b1);
        idle();
        push(5'd13, 1);
        resolve(1, '0);
        check("t4_next", upd_addr, 5'd13);

        // ---------------- resolve on empty, async reset ----------------
        resolve(1, '0);
        check("t5_err", res_err, 1'b1);
        check("t5_noupd", upd_valid, 1'b0);
        idle();
        check("t5_err_sticky", res_err, 1'b1);
        push(5'd20, 1);
        push(5'd21, 0);
        #2 arst_n = 1'b0;
        #1;
        check("t5_async_err",   res_err,    1'b0);
        check("t5_async_bcnt",  branch_cnt, 16'd0);
        check("t5_async_empty", empty,      1'b1);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        idle();

        // ---------------- en=0 freezes everything ----------------
        push(5'd2, 1);
        cyc(0, 1, 5'd9, 0, 1, 0, 32'h0000_0444);
        check("t6_noupd",   upd_valid,   1'b0);
        check("t6_noflush", flush,       1'b0);
        check("t6_bcnt",    branch_cnt,  16'd0);
        check("t6_kept",    empty,       1'b0);
        resolve(0, 32'h0000_0200);             // mispredict -> FLUSH
        cyc(0, 0, '0, 0, 0, 0, '0);            // stays in FLUSH
        check("t6_hold_flush", pred_ready, 1'b0);
        check("t6_hold_pc",    redirect_pc, 32'h0000_0200);
        resolve(1, '0);                        // ignored while flushing
        check("t6_flush_noerr", res_err, 1'b0);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 500; n++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_pv  = $urandom_range(0, 1) == 1;
            r_idx = LOWER'($urandom);
            r_pt  = $urandom_range(0, 1) == 1;
            r_rv  = ($urandom_range(0, 2) == 0);
            guess = (q.size() != 0) ? q[0].taken : ($urandom_range(0, 1) == 1);
            r_rt  = ($urandom_range(0, 7) == 0) ? !guess : guess;
            r_pc  = $urandom;
            cyc(r_en, r_pv, r_idx, r_pt, r_rv, r_rt, r_pc);
        end

        // ---------------- counter saturation ----------------
        idle();
        idle();
        @(negedge clk);
        force dut.branch_cnt = 16'hFFFF;
        #1;
        release dut.branch_cnt;
        m_bcnt = 65535;
        check("t7_forced", branch_cnt, 16'hFFFF);
        push(5'd1, 1);
        resolve(1, '0);
        check("t7_sat", branch_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
